sliced_adder_nbit: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 16-bit adder.
- Adds two WIDTH-bit operands plus carry-in using one SLICE-bit adder slice, reused over WIDTH/SLICE cycles.
- Adds a start/busy/done handshake and selectable unsigned or signed overflow detection.
- Sits in the datapath where area matters more than single-cycle latency.

---
 rtl/sliced_adder_nbit_pkg.sv | 15 +
 rtl/sliced_adder_nbit_slice.sv | 23 ++
 rtl/sliced_adder_nbit.sv | 147 ++++++++++++++
 tb/tb_sliced_adder_nbit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sliced_adder_nbit_pkg.sv
// Shared types and elaboration helpers for the sliced multi-cycle adder.
package sliced_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice counter needs at least one bit even when a single slice covers the word.
    function automatic int unsigned cnt_width(input int unsigned num_slices);
        return (num_slices <= 1) ? 1 : $clog2(num_slices);
    endfunction

endpackage

// File: rtl/sliced_adder_nbit_slice.sv
// Combinational SLICE-bit ripple-carry adder, reused every cycle by the sliced adder.
module adder_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/sliced_adder_nbit.sv
// WIDTH-bit adder built from one SLICE-bit slice iterated over WIDTH/SLICE cycles,
// with start/busy/done handshake and unsigned or signed overflow reporting.
module sliced_adder_nbit
    import sliced_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE;
    localparam int unsigned CW         = cnt_width(NUM_SLICES);
    localparam logic [CW-1:0] LAST     = CW'(NUM_SLICES - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("sliced_adder_nbit: WIDTH must be a multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             smode_q, smode_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < NUM_SLICES; i++) begin
            if (cnt_q == CW'(i)) begin
                sl_a = a_q[i*SLICE +: SLICE];
                sl_b = b_q[i*SLICE +: SLICE];
            end
        end
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Merge the slice being produced this cycle so the final edge can load sum directly.
    always_comb begin
        res_next = res_q;
        for (int unsigned i = 0; i < NUM_SLICES; i++) begin
            if (cnt_q == CW'(i)) begin
                res_next[i*SLICE +: SLICE] = sl_sum;
            end
        end
        if (smode_q) begin
            ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            ovf_next = sl_cout;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        smode_d = smode_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    smode_d = signed_mode;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = res_next;
                carry_d = sl_cout;
                if (cnt_q == LAST) begin
                    sum_d   = res_next;
                    ovf_d   = ovf_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            smode_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            smode_q <= smode_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sliced_adder_nbit.sv
// Self-checking bench: cycle-level reference for the 16/4 build plus random sweeps of 32/8 and 8/8 builds.
module tb_sliced_adder_nbit;

    localparam int N16 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, ci = 1'b0, sm = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, ovf;
    logic [15:0] sum;

    logic        start32 = 1'b0, c32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        busy32, done32, ovf32;

    logic        start8 = 1'b0, c8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        busy8, done8, ovf8;

    int n_cmp = 0;
    int n_bad = 0;

    sliced_adder_nbit #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(ci),
        .signed_mode(sm), .busy(busy), .done(done), .sum(sum), .overflow(ovf)
    );

    sliced_adder_nbit #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .carry_in(c32),
        .signed_mode(1'b0), .busy(busy32), .done(done32), .sum(sum32), .overflow(ovf32)
    );

    sliced_adder_nbit #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(c8),
        .signed_mode(1'b0), .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic sgn);
        logic [16:0] full;
        logic        o;
        full = {1'b0, x} + {1'b0, y} + {16'd0, c};
        if (sgn) o = (x[15] == y[15]) && (full[15] != x[15]);
        else     o = full[16];
        return {o, full[15:0]};
    endfunction

    // Transaction-level reference: countdown from acceptance to result delivery.
    int          m_rem  = 0;
    logic        m_done = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
    logic [15:0] m_sum  = '0, p_sum = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_sum  <= p_sum;
                    m_ovf  <= p_ovf;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                {p_ovf, p_sum} <= ref_add(a, b, ci, sm);
                m_rem          <= N16;
            end
        end
    end

    always @(negedge clk) begin
        check("cycle16", 64'({busy, done, ovf, sum}), 64'({m_rem != 0, m_done, m_ovf, m_sum}));
    end

    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic eo, input bit disturb);
        int n, nb;
        @(negedge clk);
        a = ta; b = tb; ci = tc; sm = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n  = 0;
        nb = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
            if (busy === 1'b1) nb = nb + 1;
            if (disturb && n == 1) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; sm = ~ts;
            end
            if (disturb && n == 2) start = 1'b0;
        end
        check({nm, " latency"}, 64'(n), 64'(N16));
        check({nm, " busy"}, 64'(nb), 64'(N16));
        check({nm, " sum"}, 64'(sum), 64'(es));
        check({nm, " ovf"}, 64'(ovf), 64'(eo));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        logic [32:0] e33;
        logic [8:0]  e9;

        repeat (3) @(negedge clk);
        check("reset state", 64'({busy, done, ovf, sum}), 64'(0));
        rst = 1'b0;

        run_op("min add",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("uns ovf",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("uns->sgn",  16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("sgn ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);
        run_op("sgn->uns",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0);
        run_op("sgn neg",   16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        run_op("sgn cin",   16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
        run_op("ignore st", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1);

        // Back-to-back: start held through DONE launches the second op immediately.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; ci = 1'b0; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hA5A5; b = 16'h5A5A; ci = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n = n + 1; end
        check("b2b first latency", 64'(n), 64'(N16));
        check("b2b first sum", 64'({ovf, sum}), 64'(17'h00100));
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n = n + 1; end
        check("b2b gap", 64'(n), 64'(N16 + 1));
        check("b2b second sum", 64'({ovf, sum}), 64'(17'h10000));

        // Reset two RUN cycles into an operation.
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; ci = 1'b0; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid reset", 64'({busy, done, ovf, sum}), 64'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no done after abort", 64'(done), 64'(0));
        run_op("post reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1)); start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            n = 0;
            while (done32 !== 1'b1 && n < 20) begin @(negedge clk); n = n + 1; end
            e33 = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
            check("w32 latency", 64'(n), 64'(4));
            check("w32 result", 64'({ovf32, sum32}), 64'(e33));
        end

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1)); start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            n = (done8 === 1'b1) ? 1 : 0;
            while (done8 !== 1'b1 && n < 20) begin @(negedge clk); n = n + 1; end
            if (n == 0) n = 1;
            e9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            check("w8 latency", 64'(n), 64'(1));
            check("w8 result", 64'({ovf8, sum8}), 64'(e9));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
